// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB round-robin arbiter: FSM encoding and
// the read-data value returned when a transfer is ended by the watchdog.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    // Replicated across the data width by the arbiter to form an all-zero word.
    localparam logic TIMEOUT_RDATA_BIT = 1'b0;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after last_i, wrapping around, plus a valid flag.
module apb_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_i,
    output logic                       valid_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int                cand;
        logic [IDX_W-1:0]  w_idx;
        cand    = 0;
        w_idx   = '0;
        valid_o = 1'b0;
        grant_o = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = int'(last_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            w_idx = IDX_W'(cand);
            if (req_i[w_idx]) begin
                valid_o = 1'b1;
                grant_o = w_idx;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// APB master shared by NUM_REQ requesters. Grants round-robin in IDLE,
// runs one SETUP/ACCESS transfer at a time, and ends a stuck ACCESS phase
// with an error completion once the watchdog reaches TIMEOUT_CYCLES.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  write_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]                  ready_o,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic                                slverr_o,
    output logic                                timeout_o,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [ADDR_WIDTH-1:0]               PADDR,
    output logic [DATA_WIDTH-1:0]               PWDATA,
    input  logic [DATA_WIDTH-1:0]               PRDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR
);

    localparam int  IDX_W   = $clog2(NUM_REQ);
    localparam int  CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit  WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_lastGrant;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_write;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_pickValid;
    logic [IDX_W-1:0]       w_pickIdx;
    logic                   w_inAccess;
    logic                   w_slaveDone;
    logic                   w_wdogFire;
    logic                   w_done;

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (r_lastGrant),
        .valid_o (w_pickValid),
        .grant_o (w_pickIdx)
    );

    // A slave response always beats the watchdog in the same cycle.
    assign w_inAccess  = (r_state == ST_ACCESS);
    assign w_slaveDone = w_inAccess && PREADY;
    assign w_wdogFire  = WDOG_EN && w_inAccess && !PREADY && (r_cnt == CNT_LIMIT);
    assign w_done      = w_slaveDone || w_wdogFire;

    // Transfer sequencing and the access-phase watchdog counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pickValid) begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the winner's request once at grant; later input changes are ignored.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_grant     <= '0;
            r_lastGrant <= IDX_W'(NUM_REQ - 1);
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_pickValid) begin
            r_grant     <= w_pickIdx;
            r_lastGrant <= w_pickIdx;
            r_addr      <= addr_i[w_pickIdx];
            r_wdata     <= wdata_i[w_pickIdx];
            r_write     <= write_i[w_pickIdx];
        end
    end

    // APB drive: registered values are only exposed while a transfer is in flight.
    always_comb begin
        PSEL    = (r_state != ST_IDLE);
        PENABLE = w_inAccess;
        PWRITE  = PSEL ? r_write : 1'b0;
        PADDR   = PSEL ? r_addr  : '0;
        PWDATA  = PSEL ? r_wdata : '0;
    end

    // Completion is forwarded in the completing ACCESS cycle; otherwise all zero.
    always_comb begin
        ready_o   = '0;
        rdata_o   = '0;
        slverr_o  = 1'b0;
        timeout_o = 1'b0;
        if (w_slaveDone) begin
            ready_o  = NUM_REQ'(1) << r_grant;
            rdata_o  = PRDATA;
            slverr_o = PSLVERR;
        end else if (w_wdogFire) begin
            ready_o   = NUM_REQ'(1) << r_grant;
            rdata_o   = {DATA_WIDTH{TIMEOUT_RDATA_BIT}};
            slverr_o  = 1'b1;
            timeout_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter with three requesters and a short
// watchdog. Directed scenarios plus randomized transfers are compared against
// a transaction-level model of the round-robin grant and completion rules.
module tb_apb_rr_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 4;

    logic                    ACLK;
    logic                    ARESETn;
    logic [NREQ-1:0]         reqI;
    logic [NREQ-1:0]         writeI;
    logic [NREQ-1:0][AW-1:0] addrI;
    logic [NREQ-1:0][DW-1:0] wdataI;
    logic [NREQ-1:0]         readyO;
    logic [DW-1:0]           rdataO;
    logic                    slverrO;
    logic                    timeoutO;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [AW-1:0]           PADDR;
    logic [DW-1:0]           PWDATA;
    logic [DW-1:0]           PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    int checks = 0;
    int errors = 0;
    int lastGrant;

    apb_rr_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_i     (reqI),
        .write_i   (writeI),
        .addr_i    (addrI),
        .wdata_i   (wdataI),
        .ready_o   (readyO),
        .rdata_o   (rdataO),
        .slverr_o  (slverrO),
        .timeout_o (timeoutO),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Free-running clock.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index after the last grant, circularly.
    function automatic int modelPick(input logic [NREQ-1:0] req);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (lastGrant + k) % NREQ;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic checkQuietBus(input string tag);
        checkOutput({tag, ".PSEL"},    PSEL,     0);
        checkOutput({tag, ".PENABLE"}, PENABLE,  0);
        checkOutput({tag, ".PWRITE"},  PWRITE,   0);
        checkOutput({tag, ".PADDR"},   PADDR,    0);
        checkOutput({tag, ".PWDATA"},  PWDATA,   0);
        checkOutput({tag, ".ready"},   readyO,   0);
        checkOutput({tag, ".rdata"},   rdataO,   0);
        checkOutput({tag, ".slverr"},  slverrO,  0);
        checkOutput({tag, ".timeout"}, timeoutO, 0);
    endtask

    // One complete transfer. Entered and left at a falling edge with the DUT idle.
    // readyAt is the ACCESS cycle (0-based) where the slave answers; beyond TMO the
    // watchdog ends the transfer at ACCESS cycle TMO.
    task automatic applyStimulus(input logic [NREQ-1:0] req, input int readyAt,
                                 input logic slv, input logic [DW-1:0] prd, input bit disturb);
        int             g;
        int             k;
        bit             done;
        logic [AW-1:0]  eAddr;
        logic [DW-1:0]  eData;
        logic           eWr;
        logic [NREQ-1:0] eReady;
        reqI    = req;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        #1;
        checkQuietBus("idle");
        g = modelPick(req);
        if (g < 0) begin
            checkOutput("noRequestInModel", 1, 0);
            return;
        end
        eAddr  = addrI[g];
        eData  = wdataI[g];
        eWr    = writeI[g];
        eReady = 3'b001 << g;
        @(negedge ACLK);
        checkOutput("setup.PSEL",    PSEL,    1);
        checkOutput("setup.PENABLE", PENABLE, 0);
        checkOutput("setup.PADDR",   PADDR,   eAddr);
        checkOutput("setup.PWDATA",  PWDATA,  eData);
        checkOutput("setup.PWRITE",  PWRITE,  eWr);
        checkOutput("setup.ready",   readyO,  0);
        if (disturb) begin
            reqI   = 3'($urandom);
            writeI = 3'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                addrI[i]  = $urandom;
                wdataI[i] = $urandom;
            end
        end
        k    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge ACLK);
            if (k == readyAt) begin
                PREADY  = 1'b1;
                PSLVERR = slv;
                PRDATA  = prd;
            end
            #1;
            checkOutput("access.PSEL",    PSEL,    1);
            checkOutput("access.PENABLE", PENABLE, 1);
            checkOutput("access.PADDR",   PADDR,   eAddr);
            checkOutput("access.PWDATA",  PWDATA,  eData);
            checkOutput("access.PWRITE",  PWRITE,  eWr);
            if (k == readyAt) begin
                checkOutput("done.ready",   readyO,   eReady);
                checkOutput("done.rdata",   rdataO,   prd);
                checkOutput("done.slverr",  slverrO,  slv);
                checkOutput("done.timeout", timeoutO, 0);
                done = 1'b1;
            end else if (k == TMO) begin
                checkOutput("wdog.ready",   readyO,   eReady);
                checkOutput("wdog.rdata",   rdataO,   0);
                checkOutput("wdog.slverr",  slverrO,  1);
                checkOutput("wdog.timeout", timeoutO, 1);
                done = 1'b1;
            end else begin
                checkOutput("wait.ready",   readyO,   0);
                checkOutput("wait.timeout", timeoutO, 0);
            end
            k++;
            if (!done && k > 40) begin
                checkOutput("accessBound", 0, 1);
                done = 1'b1;
            end
        end
        lastGrant = g;
        @(negedge ACLK);
    endtask

    task automatic randomizeRequesters();
        writeI = 3'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            addrI[i]  = $urandom;
            wdataI[i] = $urandom;
        end
    endtask

    initial begin
        ARESETn   = 1'b0;
        reqI      = '0;
        writeI    = '0;
        addrI     = '0;
        wdataI    = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        lastGrant = NREQ - 1;

        #3;
        checkQuietBus("reset");
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Idle bus with no requests stays quiet.
        reqI = '0;
        @(negedge ACLK);
        checkQuietBus("noReq");

        // Single read from requester 0, answered on the first ACCESS cycle.
        addrI[0]  = 32'h1A10_0004;
        wdataI[0] = 32'h0;
        writeI    = 3'b000;
        applyStimulus(3'b001, 0, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Two requesters held high must alternate.
        for (int n = 0; n < 4; n++) begin
            randomizeRequesters();
            applyStimulus(3'b011, 0, 1'b0, $urandom, 1'b0);
        end

        // Delayed write with slave error; inputs disturbed during the transfer.
        randomizeRequesters();
        writeI = 3'b111;
        applyStimulus(3'b100, 3, 1'b1, $urandom, 1'b1);

        // Watchdog expiry, then the slave answering on the expiry cycle.
        randomizeRequesters();
        applyStimulus(3'b010, 99, 1'b0, 32'h1234_5678, 1'b0);
        randomizeRequesters();
        applyStimulus(3'b010, TMO, 1'b0, 32'h8765_4321, 1'b0);

        // Reset during ACCESS drops the bus at once and restarts priority at 0.
        reqI   = 3'b011;
        PREADY = 1'b0;
        randomizeRequesters();
        @(negedge ACLK);
        @(negedge ACLK);
        #2;
        ARESETn = 1'b0;
        PREADY  = 1'b1;
        #1;
        checkOutput("rstMid.PSEL",    PSEL,    0);
        checkOutput("rstMid.PENABLE", PENABLE, 0);
        checkOutput("rstMid.ready",   readyO,  0);
        @(negedge ACLK);
        ARESETn   = 1'b1;
        PREADY    = 1'b0;
        lastGrant = NREQ - 1;
        randomizeRequesters();
        applyStimulus(3'b011, 0, 1'b0, $urandom, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            randomizeRequesters();
            applyStimulus(3'($urandom_range(1, 7)), $urandom_range(0, 6),
                          1'($urandom), $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
